// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial ALU: operation codes and controller states.
// Used by the RTL and the testbench so both agree on the numeric encodings.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // ADD and SUB carry a value between bit cycles; the logic ops do not.
  function automatic logic isArith(input op_e opSel);
    return (opSel == OP_ADD) || (opSel == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_bit.sv
// One-bit combinational ALU cell. For subtraction the caller supplies the
// inverted B bit, so the cell only ever needs to add.
module alu_bit
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       out,
  output logic       cout
);

  always_comb begin
    out  = 1'b0;
    cout = 1'b0;
    case (op_e'(op))
      OP_AND: out = a & b;
      OP_OR:  out = a | b;
      default: begin
        out  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: operands are shifted LSB first through a single alu_bit cell,
// one bit per clock; result, carry and zero update together on the final bit.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] resSh_q, resSh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic cellB;
  logic cellOut;
  logic cellCout;

  // Subtraction is a + ~b + 1: invert B here and preload the carry with 1.
  assign cellB = (op_q == OP_SUB) ? ~opB_q[0] : opB_q[0];

  alu_bit uCell (
    .a    (opA_q[0]),
    .b    (cellB),
    .cin  (cy_q),
    .op   (op_q),
    .out  (cellOut),
    .cout (cellCout)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    resSh_d  = resSh_q;
    cnt_d    = cnt_q;
    cy_d     = cy_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;

    case (state_q)
      ST_RUN: begin
        opA_d   = opA_q >> 1;
        opB_d   = opB_q >> 1;
        resSh_d = {cellOut, resSh_q[WIDTH-1:1]};
        cy_d    = isArith(op_q) ? cellCout : 1'b0;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d  = ST_DONE;
          result_d = resSh_d;
          carry_d  = cy_d;
          zero_d   = (resSh_d == '0);
        end
      end
      // IDLE and DONE both accept a new request; otherwise fall back to IDLE.
      default: begin
        if (start) begin
          state_d = ST_RUN;
          op_d    = op_e'(op);
          opA_d   = a;
          opB_d   = b;
          cnt_d   = '0;
          cy_d    = (op_e'(op) == OP_SUB);
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_AND;
      opA_q    <= '0;
      opB_q    <= '0;
      resSh_q  <= '0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      resSh_q  <= resSh_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Testbench for serial_alu: directed corner cases plus random operations checked
// against an arithmetic reference model.
module tb_serial_alu;
  import serial_alu_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;

  int checks = 0;
  int errors = 0;

  serial_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request and step past the accepting edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input bit holdStart);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    if (!holdStart) start = 1'b0;
  endtask

  task automatic waitDone(input int startEdges, output int edges, output int busyCycles);
    edges      = startEdges;
    busyCycles = startEdges;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busyCycles++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  function automatic void refModel(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   output logic [W-1:0] r, output logic c);
    int sum;
    case (o)
      2'b00: begin r = x & y; c = 1'b0; end
      2'b01: begin r = x | y; c = 1'b0; end
      2'b10: begin
        sum = int'(x) + int'(y);
        r   = sum[W-1:0];
        c   = (sum >= (1 << W));
      end
      default: begin
        r = x - y;
        c = (x >= y);
      end
    endcase
  endfunction

  task automatic checkCompletion(input string tag, input logic [1:0] o,
                                 input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int edges, input int busyCycles);
    logic [W-1:0] expR;
    logic         expC;
    refModel(o, x, y, expR, expC);
    checkOutput({tag, "_done"},    32'(done), 32'd1);
    checkOutput({tag, "_latency"}, 32'(edges), 32'(W));
    checkOutput({tag, "_busy"},    32'(busyCycles), 32'(W));
    checkOutput({tag, "_result"},  32'(result), 32'(expR));
    checkOutput({tag, "_carry"},   32'(carry), 32'(expC));
    checkOutput({tag, "_zero"},    32'(zero), 32'(expR == '0));
  endtask

  task automatic runAndCheck(input string tag, input logic [1:0] o,
                             input logic [W-1:0] x, input logic [W-1:0] y);
    int edges;
    int busyCycles;
    applyStimulus(o, x, y, 1'b0);
    waitDone(0, edges, busyCycles);
    checkCompletion(tag, o, x, y, edges, busyCycles);
    @(posedge clk);
    #1;
    checkOutput({tag, "_doneFall"}, 32'(done), 32'd0);
    checkOutput({tag, "_idleBusy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int edges;
    int busyCycles;
    int doneCount;
    logic [1:0]   rOp;
    logic [W-1:0] rA;
    logic [W-1:0] rB;

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy",   32'(busy),   32'd0);
    checkOutput("rst_done",   32'(done),   32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_carry",  32'(carry),  32'd0);
    checkOutput("rst_zero",   32'(zero),   32'd0);
    reset = 1'b0;

    runAndCheck("add7F_01", OP_ADD, 8'h7F, 8'h01);
    runAndCheck("addFF_01", OP_ADD, 8'hFF, 8'h01);
    runAndCheck("sub05_07", OP_SUB, 8'h05, 8'h07);
    runAndCheck("sub07_07", OP_SUB, 8'h07, 8'h07);
    runAndCheck("andF0_3C", OP_AND, 8'hF0, 8'h3C);
    runAndCheck("orF0_3C",  OP_OR,  8'hF0, 8'h3C);

    // A start pulse in the middle of RUN must be ignored entirely.
    applyStimulus(OP_ADD, 8'h10, 8'h20, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    op    = OP_SUB;
    a     = 8'h55;
    b     = 8'h0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(3, edges, busyCycles);
    checkCompletion("midStart", OP_ADD, 8'h10, 8'h20, edges, busyCycles);
    doneCount = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) doneCount++;
    end
    checkOutput("midStart_extraDone", 32'(doneCount), 32'd0);

    // Start held high through DONE launches the next operation back-to-back.
    applyStimulus(OP_ADD, 8'h3A, 8'h25, 1'b1);
    waitDone(0, edges, busyCycles);
    checkCompletion("b2b_first", OP_ADD, 8'h3A, 8'h25, edges, busyCycles);
    op = OP_SUB;
    a  = 8'h40;
    b  = 8'h11;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_restartBusy", 32'(busy), 32'd1);
    waitDone(0, edges, busyCycles);
    checkCompletion("b2b_second", OP_SUB, 8'h40, 8'h11, edges, busyCycles);
    @(posedge clk);
    #1;

    // Reset in the middle of an operation aborts it with no done pulse.
    applyStimulus(OP_ADD, 8'h33, 8'h44, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_busy",   32'(busy),   32'd0);
    checkOutput("abort_done",   32'(done),   32'd0);
    checkOutput("abort_carry",  32'(carry),  32'd0);
    checkOutput("abort_zero",   32'(zero),   32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    doneCount = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) doneCount++;
    end
    checkOutput("abort_noDone", 32'(doneCount), 32'd0);
    runAndCheck("afterAbort", OP_ADD, 8'hC8, 8'h64);

    for (int i = 0; i < 24; i++) begin
      rOp = 2'($urandom_range(3, 0));
      rA  = W'($urandom);
      rB  = W'($urandom);
      runAndCheck($sformatf("rand%0d", i), rOp, rA, rB);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
